// File: rtl/mem_req_if.sv
// mem_req_if: command/response handshake bundle for mem_req_ctrl (rsp_is_write only with MEM_REQ_CTRL_WR_ACK_EN)
interface mem_req_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
`ifdef MEM_REQ_CTRL_WR_ACK_EN
  logic              rsp_is_write;
`endif
  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err
`ifdef MEM_REQ_CTRL_WR_ACK_EN
    , input rsp_is_write
`endif
  );
  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err
`ifdef MEM_REQ_CTRL_WR_ACK_EN
    , output rsp_is_write
`endif
  );
endinterface

// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: FIFO-buffered request front-end for a 16x32 synchronous memory, with memory reset sequencing.
// Optional write acknowledges (rsp_is_write) are enabled by defining MEM_REQ_CTRL_WR_ACK_EN.
module mem_req_ctrl #(
  parameter int ADDR_W      = 4,
  parameter int DATA_W      = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_req_if.slave          bus,
  output logic              busy,
  output logic              mem_rst_n,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_valid_out
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(INIT_CYCLES + 1);
  typedef enum logic [2:0] {INIT, IDLE, ISSUE, WAIT_RD, RESP} state_t;
  state_t            state;
  logic [CW-1:0]     init_cnt;
  logic [PW:0]       wr_ptr, rd_ptr;
  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic              q_wr   [FIFO_DEPTH];
  logic              empty, full, push;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign bus.cmd_ready = state != INIT && !full;
  assign push = bus.cmd_valid && bus.cmd_ready;
  assign busy = !rst && (!empty || state != IDLE);
  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[wr_ptr[PW-1:0]] <= bus.cmd_addr;
      q_data[wr_ptr[PW-1:0]] <= bus.cmd_wdata;
      q_wr[wr_ptr[PW-1:0]]   <= bus.cmd_write;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= INIT;
      init_cnt         <= '0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      mem_rst_n        <= 1'b0;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      mem_addr         <= '0;
      mem_data_in      <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
      bus.rsp_err      <= 1'b0;
`ifdef MEM_REQ_CTRL_WR_ACK_EN
      bus.rsp_is_write <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      mem_write_enable <= 1'b0;
      mem_read_enable  <= 1'b0;
      case (state)
        INIT: begin
          if (init_cnt == CW'(INIT_CYCLES - 1)) begin
            state     <= IDLE;
            mem_rst_n <= 1'b1;
          end else init_cnt <= init_cnt + 1'b1;
        end
        IDLE: begin
          if (!empty) begin
            state            <= ISSUE;
            rd_ptr           <= rd_ptr + 1'b1;
            mem_addr         <= q_addr[rd_ptr[PW-1:0]];
            mem_data_in      <= q_data[rd_ptr[PW-1:0]];
            mem_write_enable <= q_wr[rd_ptr[PW-1:0]];
            mem_read_enable  <= !q_wr[rd_ptr[PW-1:0]];
          end
        end
`ifdef MEM_REQ_CTRL_WR_ACK_EN
        ISSUE: begin
          state <= mem_write_enable ? RESP : WAIT_RD;
          if (mem_write_enable) begin
            bus.rsp_valid    <= 1'b1;
            bus.rsp_rdata    <= '0;
            bus.rsp_err      <= 1'b0;
            bus.rsp_is_write <= 1'b1;
          end
        end
`else
        ISSUE: state <= mem_write_enable ? IDLE : WAIT_RD;
`endif
        WAIT_RD: begin
          // memory data_out was updated at the ISSUE edge, so it is sampled here
          bus.rsp_rdata <= mem_data_out;
          bus.rsp_err   <= ~mem_valid_out;
          bus.rsp_valid <= 1'b1;
`ifdef MEM_REQ_CTRL_WR_ACK_EN
          bus.rsp_is_write <= 1'b0;
`endif
          state <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_req_ctrl.sv
// tb_mem_req_ctrl: randomized + directed bench for mem_req_ctrl against a transaction-level model and a memory model.
module tb_mem_req_ctrl;
  localparam int AW = 4, DW = 32, DEPTH = 4, INITC = 2;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  mem_req_if #(.ADDR_W(AW), .DATA_W(DW)) ifc ();
  logic busy, mem_rst_n, mem_we, mem_re, mem_vout;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, mem_dout;
  mem_req_ctrl #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH), .INIT_CYCLES(INITC)) dut (
    .clk(clk), .rst(rst), .bus(ifc), .busy(busy), .mem_rst_n(mem_rst_n),
    .mem_write_enable(mem_we), .mem_read_enable(mem_re), .mem_addr(mem_addr),
    .mem_data_in(mem_din), .mem_data_out(mem_dout), .mem_valid_out(mem_vout));

  int checks = 0, errors = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
    end
  endtask
  task automatic fail(input string n);
    checks++;
    errors++;
    $display("FAIL %s timed out at %0t", n, $time);
  endtask

  // memory stand-in: synchronous active-low reset, read data and valid appear the edge after read_enable
  logic [DW-1:0] mem [16];
  logic mvld, bad_q, inj_next;
  always @(posedge clk) begin
    if (!mem_rst_n) begin
      mem_dout <= '0;
      mvld <= 1'b0;
      bad_q <= 1'b0;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_din;
      if (mem_re) mem_dout <= mem[mem_addr];
      mvld <= mem_re;
      bad_q <= mem_re && inj_next;
    end
  end
  assign mem_vout = mvld && !bad_q;

  int cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else if (cyc < 1000) cyc <= cyc + 1;

  typedef struct {logic w; logic [AW-1:0] a; logic [DW-1:0] d;} cmd_t;
  typedef struct {logic [DW-1:0] d; logic e; logic w; int t;} rsp_t;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];
  cmd_t c;
  logic [DW-1:0] ref_mem [16];
  int acc, iss, done, ncyc;
  logic prev_en, init_done, rv;
  logic [AW-1:0] last_a;
  logic [DW-1:0] last_d;
  bit force_err = 0, rand_err = 0;

  // model: count accepted/issued/completed commands, predict issue contents and responses in FIFO order
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_flags", {ifc.cmd_ready, ifc.rsp_valid, ifc.rsp_err, busy, mem_rst_n, mem_we, mem_re}, 0);
      chk("rst_rdata", ifc.rsp_rdata, 0);
      chk("rst_mem_bus", {mem_addr, mem_din}, 0);
      cmd_q.delete();
      rsp_q.delete();
      acc = 0; iss = 0; done = 0; prev_en = 0; last_a = 0; last_d = 0; inj_next = 0;
    end else begin
      ncyc++;
      init_done = cyc >= INITC;
      chk("mem_rst_n", mem_rst_n, init_done);
      chk("en_both", mem_we & mem_re, 0);
      chk("en_pulse", (mem_we | mem_re) & prev_en, 0);
      if (mem_we | mem_re) begin
        if (cmd_q.size() == 0) fail("issue_without_cmd");
        else begin
          c = cmd_q.pop_front();
          chk("issue_kind", mem_we, c.w);
          chk("issue_addr", mem_addr, c.a);
          chk("issue_data", mem_din, c.d);
          last_a = c.a;
          last_d = c.d;
          iss++;
          inj_next = !c.w && (force_err || (rand_err && $urandom_range(0, 4) == 0));
          if (c.w) begin
            ref_mem[c.a] = c.d;
`ifdef MEM_REQ_CTRL_WR_ACK_EN
            rsp_q.push_back('{d: '0, e: 1'b0, w: 1'b1, t: ncyc + 1});
`endif
          end else rsp_q.push_back('{d: ref_mem[c.a], e: inj_next, w: 1'b0, t: ncyc + 2});
        end
      end
      chk("mem_addr", mem_addr, last_a);
      chk("mem_data_in", mem_din, last_d);
      chk("cmd_ready", ifc.cmd_ready, init_done && (acc - iss) < DEPTH);
      rv = rsp_q.size() > 0 && ncyc >= rsp_q[0].t;
      chk("rsp_valid", ifc.rsp_valid, rv);
      if (rv) begin
        chk("rsp_rdata", ifc.rsp_rdata, rsp_q[0].d);
        chk("rsp_err", ifc.rsp_err, rsp_q[0].e);
`ifdef MEM_REQ_CTRL_WR_ACK_EN
        chk("rsp_is_write", ifc.rsp_is_write, rsp_q[0].w);
`endif
      end
      chk("busy", busy, !init_done || acc != done);
      if (rv && ifc.rsp_ready) begin
        void'(rsp_q.pop_front());
        done++;
      end
`ifndef MEM_REQ_CTRL_WR_ACK_EN
      if (mem_we) done++;
`endif
      if (ifc.cmd_valid && ifc.cmd_ready) begin
        cmd_q.push_back('{w: ifc.cmd_write, a: ifc.cmd_addr, d: ifc.cmd_wdata});
        acc++;
      end
      prev_en = mem_we | mem_re;
    end
  end

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    ifc.cmd_valid = 1; ifc.cmd_write = w; ifc.cmd_addr = a; ifc.cmd_wdata = d;
    do begin @(negedge clk); n++; end while (!ifc.cmd_ready && n < 200);
    if (!ifc.cmd_ready) fail("send");
    @(posedge clk); #1 ifc.cmd_valid = 0;
  endtask
  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while ((busy || ifc.rsp_valid) && n < 1000);
    if (busy || ifc.rsp_valid) fail("wait_idle");
    @(posedge clk); #1;
  endtask
  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!ifc.rsp_valid && lat < 50);
    if (!ifc.rsp_valid) fail("wait_rsp");
  endtask
  task automatic init_seq();
    for (int i = 0; i <= INITC; i++) begin
      @(negedge clk);
      chk("init_mem_rst_n", mem_rst_n, i >= INITC);
      chk("init_cmd_ready", ifc.cmd_ready, i >= INITC);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    fail("watchdog");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, n_acc;
    ifc.cmd_valid = 0; ifc.cmd_write = 0; ifc.cmd_addr = 0; ifc.cmd_wdata = 0; ifc.rsp_ready = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    init_seq();
    for (int a = 0; a < 16; a++) send(1, 4'(a), $urandom);
    wait_idle();
    // single write: one-cycle enable with the right address
    send(1, 5, 32'hDEADBEEF);
    @(negedge clk);
    @(negedge clk);
    chk("wr_enable", {mem_we, mem_re}, 2'b10);
    chk("wr_addr", mem_addr, 5);
    @(negedge clk);
    chk("wr_enable_drop", mem_we, 0);
    @(posedge clk); #1;
    wait_idle();
    send(0, 5, 0);
    wait_rsp(lat);
    chk("rd_latency", lat, 4);
    chk("rd_data", ifc.rsp_rdata, 32'hDEADBEEF);
    chk("rd_err", ifc.rsp_err, 0);
    @(posedge clk); #1;
    wait_idle();
    // stalled response keeps the FIFO from draining so it fills to DEPTH
    ifc.rsp_ready = 0;
    send(0, 7, 0);
    wait_rsp(lat);
    @(posedge clk); #1;
    n_acc = 0;
    ifc.cmd_valid = 1; ifc.cmd_write = 1; ifc.cmd_addr = $urandom; ifc.cmd_wdata = $urandom;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (!ifc.cmd_ready) break;
      n_acc++;
      @(posedge clk); #1 ifc.cmd_addr = $urandom; ifc.cmd_wdata = $urandom;
    end
    chk("fifo_full_accepts", n_acc, DEPTH);
    @(posedge clk); #1 ifc.cmd_valid = 0; ifc.rsp_ready = 1;
    wait_idle();
    // backpressure hold
    send(1, 3, 32'h12345678);
    wait_idle();
    ifc.rsp_ready = 0;
    send(0, 3, 0);
    wait_rsp(lat);
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      chk("bp_valid", ifc.rsp_valid, 1);
      chk("bp_rdata", ifc.rsp_rdata, 32'h12345678);
    end
    @(posedge clk); #1 ifc.rsp_ready = 1;
    @(negedge clk);
    chk("bp_valid_pending", ifc.rsp_valid, 1);
    @(negedge clk);
    chk("bp_valid_drop", ifc.rsp_valid, 0);
    @(posedge clk); #1;
    wait_idle();
    // memory valid low at capture
    force_err = 1;
    send(0, 9, 0);
    wait_rsp(lat);
    chk("err_flag", ifc.rsp_err, 1);
    @(posedge clk); #1 force_err = 0;
    wait_idle();
    // asynchronous reset while a read sits in WAIT_RD with two commands queued
    send(0, 2, 0);
    send(1, 4, $urandom);
    send(1, 6, $urandom);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst = 1;
    #1;
    chk("rst_async_flags", {mem_we, mem_re, ifc.rsp_valid, busy, mem_rst_n}, 0);
    @(posedge clk);
    @(posedge clk); #1 rst = 0;
    init_seq();
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_quiet", {ifc.rsp_valid, mem_we, mem_re}, 0);
    end
    @(posedge clk); #1;
    // randomized traffic, then a phase with heavy backpressure
    rand_err = 1;
    repeat (400) begin
      ifc.cmd_valid = 1'($urandom_range(0, 1)); ifc.cmd_write = 1'($urandom_range(0, 1));
      ifc.cmd_addr = 4'($urandom); ifc.cmd_wdata = $urandom; ifc.rsp_ready = $urandom_range(0, 3) != 0;
      @(posedge clk); #1;
    end
    repeat (300) begin
      ifc.cmd_valid = 1'($urandom_range(0, 1)); ifc.cmd_write = 1'($urandom_range(0, 1));
      ifc.cmd_addr = 4'($urandom); ifc.cmd_wdata = $urandom; ifc.rsp_ready = $urandom_range(0, 3) == 0;
      @(posedge clk); #1;
    end
    ifc.cmd_valid = 0; ifc.rsp_ready = 1; rand_err = 0;
    wait_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
